// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and sequencer FSM states.
// Pure declarations; no logic or timing of its own.
package cpu_pkg;

  localparam logic [3:0] OP_SET    = 4'd0;
  localparam logic [3:0] OP_COPY   = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_INC    = 4'd3;
  localparam logic [3:0] OP_SUB    = 4'd4;
  localparam logic [3:0] OP_DEC    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_SKIPIF = 4'd9;
  localparam logic [3:0] OP_HALT   = 4'd10;
  localparam logic [3:0] OP_NOP    = 4'd15;

  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int DST_HI = 7;
  localparam int DST_LO = 4;
  localparam int SRC_HI = 3;
  localparam int SRC_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  // Opcodes 11..14 are unassigned; they still execute as NOPs but are flagged.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd11) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/issue/execute sequencer: drives the PC, presents instruction fields to the decoder, steps on skip/halt.
// Three cycles per instruction with zero-wait memory; every memory wait cycle stretches FETCH by one.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_data,
  output logic [3:0]      opcode,
  output logic [3:0]      dst,
  output logic [3:0]      src,
  output logic            issue,
  input  logic            skip_in,
  input  logic            halt_in,
  input  logic            cond,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     retired
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_req;
  logic [3:0]      r_opcode;
  logic [3:0]      r_dst;
  logic [3:0]      r_src;
  logic            r_issue;
  logic            r_illegal;
  logic            r_halted;
  logic [15:0]     r_retired;

  logic [3:0]      w_fetch_op;
  logic [PC_W-1:0] w_pc_step;

  assign w_fetch_op = imem_data[OPC_HI:OPC_LO];
  // Halt outranks skip; a skip needs both the decoder request and the datapath condition.
  assign w_pc_step  = (!halt_in && skip_in && cond) ? PC_TWO : PC_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_req     <= 1'b0;
      r_opcode  <= OP_NOP;
      r_dst     <= 4'd0;
      r_src     <= 4'd0;
      r_issue   <= 1'b0;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= 16'd0;
    end else begin
      r_issue   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_opcode  <= w_fetch_op;
            r_dst     <= imem_data[DST_HI:DST_LO];
            r_src     <= imem_data[SRC_HI:SRC_LO];
            r_issue   <= 1'b1;
            r_illegal <= is_illegal(w_fetch_op);
            r_req     <= 1'b0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_EXEC;
        S_EXEC: begin
          if (r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
          r_pc <= r_pc + w_pc_step;
          if (halt_in) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_halted <= 1'b0;
            r_req    <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign imem_req  = r_req;
  assign opcode    = r_opcode;
  assign dst       = r_dst;
  assign src       = r_src;
  assign issue     = r_issue;
  assign illegal   = r_illegal;
  assign halted    = r_halted;
  assign retired   = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level program model, memory and one-cycle decoder stand-ins.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int PC_W = 8;
  localparam int IW   = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_valid = 1'b0;
  logic [IW-1:0]   imem_data = '0;
  logic [3:0]      opcode, dst, src;
  logic            issue;
  logic            skip_in = 1'b0;
  logic            halt_in = 1'b0;
  logic            cond = 1'b0;
  logic            halted, illegal;
  logic [15:0]     retired;

  instr_sequencer #(.PC_W(PC_W), .IW(IW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .opcode(opcode), .dst(dst), .src(src), .issue(issue),
    .skip_in(skip_in), .halt_in(halt_in), .cond(cond),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] word;
    logic [15:0] ret;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          waits = 0;
  bit          noise = 1'b0;
  int          last_issue = -1;
  int          ill_cnt = 0;
  logic [11:0] mem [256];
  exp_t        exp_q[$];
  logic [7:0]  fetch_q[$];
  logic [7:0]  fetch_log[$];
  int          issue_log[$];
  logic [7:0]  m_pc = 8'd0;
  logic [15:0] m_ret = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Instruction-level execution: walk the program from the model PC to the next HALT.
  task automatic model_run();
    for (int k = 0; k < 400; k++) begin
      exp_t       e;
      logic [3:0] op;
      e.addr = m_pc;
      e.word = mem[m_pc];
      e.ret  = m_ret;
      exp_q.push_back(e);
      op = e.word[11:8];
      if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      if (op == OP_HALT) begin
        m_pc = m_pc + 8'd1;
        break;
      end
      m_pc = m_pc + (((op == OP_SKIPIF) && cond) ? 8'd2 : 8'd1);
    end
  endtask

  // Memory: answers after `waits` request cycles; optionally asserts junk valid when not requested.
  initial begin : memdrv
    int wc;
    wc = 0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (wc >= waits) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
          fetch_q.push_back(imem_addr);
          fetch_log.push_back(imem_addr);
        end else begin
          imem_valid = 1'b0;
          imem_data  = 12'h000;
        end
        wc++;
      end else begin
        wc = 0;
        imem_valid = noise;
        imem_data  = noise ? 12'hA00 : 12'h000;
      end
    end
  end

  // Decoder stand-in: skip/halt follow the opcode presented one cycle earlier.
  initial begin : decoder
    logic [3:0] op_s;
    forever begin
      @(negedge clk);
      op_s = opcode;
      @(posedge clk);
      #1;
      skip_in = (op_s == OP_SKIPIF);
      halt_in = (op_s == OP_HALT);
    end
  end

  initial begin : compare
    logic [3:0] h_op, h_dst, h_src, eop;
    exp_t       e;
    h_op = 4'hF; h_dst = 4'd0; h_src = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1) begin
        h_op = 4'hF; h_dst = 4'd0; h_src = 4'd0;
      end else if (issue === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          eop = e.word[11:8];
          chk("issue_opcode", opcode, eop);
          chk("issue_dst", dst, e.word[7:4]);
          chk("issue_src", src, e.word[3:0]);
          chk("issue_illegal", illegal, (eop >= 4'd11 && eop <= 4'd14));
          chk("retired_at_issue", retired, e.ret);
          chk("halted_at_issue", halted, 1'b0);
          if (fetch_q.size() == 0) chk("fetch_missing", 32'd1, 32'd0);
          else chk("fetch_addr", fetch_q.pop_front(), e.addr);
          if (last_issue >= 0) chk("issue_interval", cyc - last_issue, 3 + waits);
          last_issue = cyc;
          issue_log.push_back(cyc - start_cyc);
          if (illegal === 1'b1) ill_cnt++;
          h_op = eop; h_dst = e.word[7:4]; h_src = e.word[3:0];
        end
      end else begin
        chk("hold_opcode", opcode, h_op);
        chk("hold_dst", dst, h_dst);
        chk("hold_src", src, h_src);
        chk("illegal_no_issue", illegal, 1'b0);
      end
    end
  end

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_halted"}, halted, 1'b1);
  endtask

  task automatic pulse_start(input int poke_off);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    last_issue = -1;
    @(negedge clk);
    start = 1'b0;
    if (poke_off > 0) begin
      repeat (poke_off - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run(input string nm, input int poke_off);
    model_run();
    fetch_log.delete();
    issue_log.delete();
    pulse_start(poke_off);
    wait_halt(nm);
    chk({nm, "_pc"}, imem_addr, m_pc);
    chk({nm, "_retired"}, retired, m_ret);
    chk({nm, "_all_issued"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    fetch_q.delete();
    reset = 1'b1;
    m_pc = 8'd0;
    m_ret = 16'd0;
  endtask

  function automatic int ilog(input int i);
    return (issue_log.size() > i) ? issue_log[i] : -1;
  endfunction

  function automatic int flog(input int i);
    return (fetch_log.size() > i) ? int'(fetch_log[i]) : -1;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    repeat (3) @(negedge clk);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_opcode", opcode, 4'hF);
    chk("rst_dst", dst, 4'h0);
    chk("rst_src", src, 4'h0);
    chk("rst_issue", issue, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 16'd0);
    reset = 1'b1;

    // Straight line: ADD, INC, HALT.
    mem[0] = 12'h212; mem[1] = 12'h330; mem[2] = 12'hA00;
    run("line", 0);
    chk("line_issue0", ilog(0), 2);
    chk("line_issue1", ilog(1), 5);
    chk("line_issue2", ilog(2), 8);
    chk("line_pc_lit", imem_addr, 8'd3);
    chk("line_ret_lit", retired, 16'd3);

    // Resume after halt; SKIPIF at 4 with cond=1 jumps to 6.
    mem[3] = 12'hF00; mem[4] = 12'h900; mem[5] = 12'hA00; mem[6] = 12'hA00;
    cond = 1'b1;
    run("skip1", 0);
    chk("skip1_fetch1", flog(1), 4);
    chk("skip1_fetch2", flog(2), 6);
    chk("skip1_pc_lit", imem_addr, 8'd7);

    // Reset during a fetch that is answered in the same cycle, together with start.
    @(negedge clk);
    fetch_q.delete();
    do_reset();
    mem[0] = 12'h212; mem[1] = 12'h330; mem[2] = 12'hF00; mem[3] = 12'hF00;
    mem[4] = 12'h900; mem[5] = 12'hA00;
    cond = 1'b0;
    model_run();
    pulse_start(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_opcode", opcode, 4'hF);
    chk("mid_rst_addr", imem_addr, 8'h00);
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_retired", retired, 16'd0);
    exp_q.delete();
    fetch_q.delete();
    m_pc = 8'd0;
    m_ret = 16'd0;
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_idle_req", imem_req, 1'b0);

    // Refetch from 0; SKIPIF at 4 with cond=0 falls through to 5.
    run("noskip", 0);
    chk("noskip_fetch0", flog(0), 0);
    chk("noskip_fetch5", flog(5), 5);
    chk("noskip_pc_lit", imem_addr, 8'd6);

    // Two wait states, illegal opcode, start during EXEC, stray memory valids.
    waits = 2;
    noise = 1'b1;
    ill_cnt = 0;
    mem[6] = 12'hC45; mem[7] = 12'h112; mem[8] = 12'hA00;
    run("wait", 5);
    chk("wait_issue0", ilog(0), 4);
    chk("wait_issue1", ilog(1), 9);
    chk("wait_illegal_cnt", ill_cnt, 1);
    chk("wait_ret_lit", retired, 16'd9);
    waits = 0;
    noise = 1'b0;

    // ADD at 8'hFF wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    mem[0] = 12'hA00; mem[8'hFE] = 12'hA00; mem[8'hFF] = 12'h212;
    run("wrapa0", 0);
    run("wrapa1", 0);
    run("wrapa2", 0);
    chk("wrap_add_fetch0", flog(0), 8'hFF);
    chk("wrap_add_fetch1", flog(1), 8'h00);

    // SKIPIF at 8'hFF with cond=1 lands on 1.
    do_reset();
    cond = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    mem[1] = 12'hA00; mem[8'hFE] = 12'hA00; mem[8'hFF] = 12'h900;
    run("wraps0", 0);
    run("wraps1", 0);
    run("wraps2", 0);
    chk("wrap_skip_fetch0", flog(0), 8'hFF);
    chk("wrap_skip_fetch1", flog(1), 8'h01);
    chk("wrap_skip_pc_lit", imem_addr, 8'h02);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
